sort_result_collector: RTL and testbench

- Downstream consumer of the serial sorter.
- Watches the sorter's ready flag and captures N sorted words streamed one per cycle.
- Stores the words in an internal register file and computes min, max, median and signed sum.
- Optionally verifies the stream is non-decreasing, then presents results to the host with a valid/ack handshake and random read-back.

---
 rtl/sort_result_collector_if.sv | 30 +++
 rtl/sort_result_collector.sv | 76 +++++++
 tb/tb_sort_result_collector.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/sort_result_collector_if.sv
// sort_result_collector_if: host/sorter-facing bundle of the sort result collector
// master: drives ready_i, data_serial_i, ack_i, rd_addr_i and observes the results
// slave : the collector itself
interface sort_result_collector_if #(
  parameter int WIDTH = 32,
  parameter int N = 10
);
  localparam int AW = $clog2(N);
  logic ready_i;
  logic signed [WIDTH-1:0] data_serial_i;
  logic ack_i;
  logic [AW-1:0] rd_addr_i;
  logic signed [WIDTH-1:0] rd_data_o;
  logic result_valid_o;
  logic signed [WIDTH-1:0] min_o;
  logic signed [WIDTH-1:0] max_o;
  logic signed [WIDTH-1:0] median_o;
  logic signed [WIDTH+AW-1:0] sum_o;
  logic order_err_o;
  logic overrun_o;
  logic busy_o;
  modport master (
    output ready_i, data_serial_i, ack_i, rd_addr_i,
    input rd_data_o, result_valid_o, min_o, max_o, median_o, sum_o, order_err_o, overrun_o, busy_o
  );
  modport slave (
    input ready_i, data_serial_i, ack_i, rd_addr_i,
    output rd_data_o, result_valid_o, min_o, max_o, median_o, sum_o, order_err_o, overrun_o, busy_o
  );
endinterface

// File: rtl/sort_result_collector.sv
// sort_result_collector: captures an N-word sorted frame, reports min/max/median/sum with valid/ack and read-back
// Ports: clk, rst (async, active-high), bus (sort_result_collector_if.slave):
//   ready_i/data_serial_i frame input, ack_i/result_valid_o host handshake, rd_addr_i/rd_data_o read-back,
//   min_o/max_o/median_o/sum_o results, order_err_o, overrun_o (sticky), busy_o.
// Optional: define ORDER_CHECK_EN to flag frames that are not non-decreasing.
module sort_result_collector #(
  parameter int WIDTH = 32,
  parameter int N = 10
) (
  input logic clk,
  input logic rst,
  sort_result_collector_if.slave bus
);
  localparam int AW = $clog2(N);
  localparam int CW = $clog2(N + 1);
  localparam int SW = WIDTH + AW;
  localparam logic [CW-1:0] FULL = CW'(N);
  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;
  state_t state_q, state_d;
  logic ready_q, armed_q, start, first, wr_en;
  logic [CW-1:0] count_q, wr_idx;
  logic signed [WIDTH-1:0] mem [N];
  logic signed [SW-1:0] sum_q;
  logic overrun_q;
  // armed_q blocks a "start" from a ready_i that was already high when reset released
  assign start = bus.ready_i & ~ready_q & armed_q;
  assign first = (state_q == IDLE) && start;
  // count_q == FULL marks the settle cycle between the last write and DONE
  assign wr_en = first || (state_q == CAPTURE && count_q != FULL);
  assign wr_idx = first ? '0 : count_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = first ? CAPTURE
            : (state_q == CAPTURE && count_q == FULL) ? DONE
            : (state_q == DONE && bus.ack_i) ? IDLE
            : state_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ready_q <= 1'b0;
      armed_q <= 1'b0;
      count_q <= '0;
      sum_q <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else begin
      ready_q <= bus.ready_i;
      armed_q <= armed_q | ~bus.ready_i;
      if (state_q == DONE && start) overrun_q <= 1'b1;
      if (wr_en) begin
        mem[AW'(wr_idx)] <= bus.data_serial_i;
        sum_q <= first ? SW'(bus.data_serial_i) : sum_q + SW'(bus.data_serial_i);
        count_q <= wr_idx + 1'b1;
      end
    end
`ifdef ORDER_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) err_q <= 1'b0;
    else if (first) err_q <= 1'b0;
    else if (wr_en && bus.data_serial_i < mem[AW'(count_q - 1'b1)]) err_q <= 1'b1;
  assign bus.order_err_o = err_q;
`else
  assign bus.order_err_o = 1'b0;
`endif
  assign bus.rd_data_o = int'(bus.rd_addr_i) < N ? mem[bus.rd_addr_i] : '0;
  assign bus.result_valid_o = state_q == DONE;
  assign bus.busy_o = state_q == CAPTURE;
  assign bus.min_o = mem[0];
  assign bus.max_o = mem[N-1];
  assign bus.median_o = mem[(N-1)/2];
  assign bus.sum_o = sum_q;
  assign bus.overrun_o = overrun_q;
endmodule

// File: tb/tb_sort_result_collector.sv
// tb_sort_result_collector: randomized self-checking bench for sort_result_collector against a frame-level model
module tb_sort_result_collector;
  localparam int WIDTH = 32;
  localparam int N = 10;
  localparam int AW = $clog2(N);
  logic clk = 1'b0;
  logic rst;
  always #20 clk = ~clk;
  sort_result_collector_if #(.WIDTH(WIDTH), .N(N)) bus ();
  sort_result_collector #(.WIDTH(WIDTH), .N(N)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_cmp = 0;
  int n_bad = 0;
  int frame [N];
  logic exp_overrun = 1'b0;
  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_frame(input int w [N]);
    bus.ready_i = 1'b0;
    tick();
    bus.ready_i = 1'b1;
    bus.data_serial_i = w[0];
    tick();
    for (int i = 1; i < N; i++) begin
      bus.data_serial_i = w[i];
      tick();
    end
    bus.data_serial_i = $urandom;
    check("busy_after_n", bus.busy_o, 1);
    check("valid_after_n", bus.result_valid_o, 0);
    tick();
    frame = w;
  endtask
  task automatic check_results();
    longint s = 0;
    logic err = 1'b0;
    for (int i = 0; i < N; i++) begin
      s += frame[i];
      if (i > 0 && frame[i] < frame[i-1]) err = 1'b1;
    end
    check("valid", bus.result_valid_o, 1);
    check("busy_done", bus.busy_o, 0);
    check("min", bus.min_o, frame[0]);
    check("max", bus.max_o, frame[N-1]);
    check("median", bus.median_o, frame[(N-1)/2]);
    check("sum", bus.sum_o, s);
`ifdef ORDER_CHECK_EN
    check("order_err", bus.order_err_o, err);
`else
    check("order_err", bus.order_err_o, 0);
`endif
    check("overrun", bus.overrun_o, exp_overrun);
    for (int a = 0; a < (1 << AW); a++) begin
      bus.rd_addr_i = AW'(a);
      #1;
      check($sformatf("rd_data[%0d]", a), bus.rd_data_o, a < N ? frame[a] : 0);
    end
  endtask
  task automatic do_ack();
    bus.ack_i = 1'b1;
    tick();
    bus.ack_i = 1'b0;
    check("valid_after_ack", bus.result_valid_o, 0);
    check("busy_after_ack", bus.busy_o, 0);
  endtask
  task automatic check_idle_zero(input string tag);
    check({tag, "_valid"}, bus.result_valid_o, 0);
    check({tag, "_busy"}, bus.busy_o, 0);
    check({tag, "_min"}, bus.min_o, 0);
    check({tag, "_max"}, bus.max_o, 0);
    check({tag, "_median"}, bus.median_o, 0);
    check({tag, "_sum"}, bus.sum_o, 0);
    check({tag, "_overrun"}, bus.overrun_o, 0);
    check({tag, "_order_err"}, bus.order_err_o, 0);
    check({tag, "_rd_data"}, bus.rd_data_o, 0);
  endtask
  task automatic random_frame(input bit sorted, output int w [N]);
    int q [$];
    for (int i = 0; i < N; i++) q.push_back(int'($urandom));
    if (sorted) q.sort();
    for (int i = 0; i < N; i++) w[i] = q[i];
  endtask
  initial begin
    int w [N];
    rst = 1'b1;
    bus.ready_i = 1'b1;
    bus.ack_i = 1'b0;
    bus.rd_addr_i = '0;
    bus.data_serial_i = 32'sd77;
    tick();
    tick();
    check_idle_zero("reset");
    rst = 1'b0;
    repeat (4) tick();
    check_idle_zero("ready_high_release");
    w = '{-5, -3, 0, 1, 2, 4, 7, 9, 100, 2147483647};
    send_frame(w);
    check_results();
    check("basic_sum_const", bus.sum_o, 64'sd2147483762);
    do_ack();
    w = '{1, 2, 3, 9, 4, 5, 6, 7, 8, 10};
    send_frame(w);
    check_results();
    do_ack();
    random_frame(1'b1, w);
    send_frame(w);
    bus.ready_i = 1'b0;
    tick();
    bus.ready_i = 1'b1;
    bus.data_serial_i = $urandom;
    tick();
    tick();
    exp_overrun = 1'b1;
    check_results();
    bus.ready_i = 1'b0;
    tick();
    bus.ready_i = 1'b1;
    bus.ack_i = 1'b1;
    tick();
    bus.ack_i = 1'b0;
    check("ack_start_valid", bus.result_valid_o, 0);
    check("ack_start_busy", bus.busy_o, 0);
    repeat (3) tick();
    check("ack_start_no_capture", bus.busy_o, 0);
    check("ack_start_overrun", bus.overrun_o, 1);
    for (int f = 0; f < 6; f++) begin
      random_frame(f % 3 != 0, w);
      send_frame(w);
      check_results();
      repeat ($urandom_range(0, 3)) tick();
      check("held_min", bus.min_o, frame[0]);
      do_ack();
    end
    bus.ready_i = 1'b0;
    tick();
    bus.ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.data_serial_i = $urandom;
      tick();
    end
    check("mid_busy", bus.busy_o, 1);
    #5 rst = 1'b1;
    #1;
    bus.rd_addr_i = '0;
    #1;
    check_idle_zero("async_reset");
    exp_overrun = 1'b0;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("post_reset_no_capture", bus.busy_o, 0);
    check("post_reset_valid", bus.result_valid_o, 0);
    random_frame(1'b1, w);
    send_frame(w);
    check_results();
    do_ack();
    for (int i = 0; i < N; i++) w[i] = int'(32'h8000_0000);
    send_frame(w);
    check_results();
    check("neg_sum_const", bus.sum_o, -64'sd21474836480);
    bus.rd_addr_i = AW'(15);
    #1;
    check("rd_oob_15", bus.rd_data_o, 0);
    do_ack();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
